// File: rtl/mic_sample_receiver.sv
`default_nettype none
// ============================================================================
// Module      : mic_sample_receiver
// Description : Serial ADC receiver for the microphone Pmod. Generates CS/SCLK
//               at a fixed sample rate and captures one 12-bit sample per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module mic_sample_receiver #(
    parameter int CLK_DIV    = 25,
    parameter int SAMPLE_DIV = 5000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        mic_sdata,
    output logic        mic_cs_n,
    output logic        mic_sclk,
    output logic [11:0] sample,
    output logic        sample_valid,
    output logic        frame_error,
    output logic        overrun
);

    localparam int c_TIMER_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(SAMPLE_DIV - 1);
    localparam logic [c_DIV_W-1:0]   c_DIV_LAST   = c_DIV_W'(CLK_DIV - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SETUP = 2'd1;
    localparam logic [1:0] c_ST_SHIFT = 2'd2;
    localparam logic [1:0] c_ST_HOLD  = 2'd3;

    logic [c_TIMER_W-1:0] r_timer;
    logic [c_DIV_W-1:0]   r_div;
    logic [1:0]           r_state;
    logic [3:0]           r_bit;
    logic [15:0]          r_shift;
    logic                 w_tick;
    logic                 w_div_last;

    assign w_tick     = enable && (r_timer == c_TIMER_LAST);
    assign w_div_last = (r_div == c_DIV_LAST);

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            r_timer <= '0;
        end else if (w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_div        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            mic_cs_n     <= 1'b1;
            mic_sclk     <= 1'b1;
            sample       <= '0;
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
            // A tick that lands mid-frame is dropped; the frame carries on untouched.
            overrun      <= w_tick && (r_state != c_ST_IDLE);
            case (r_state)
                c_ST_IDLE: begin
                    if (w_tick) begin
                        r_state  <= c_ST_SETUP;
                        mic_cs_n <= 1'b0;
                        r_div    <= '0;
                        r_bit    <= '0;
                        r_shift  <= '0;
                    end
                end
                c_ST_SETUP: begin
                    if (w_div_last) begin
                        r_state  <= c_ST_SHIFT;
                        mic_sclk <= 1'b0;
                        r_div    <= '0;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                c_ST_SHIFT: begin
                    if (w_div_last) begin
                        r_div <= '0;
                        if (!mic_sclk) begin
                            mic_sclk <= 1'b1;
                            r_shift  <= {r_shift[14:0], mic_sdata};
                        end else if (r_bit == 4'd15) begin
                            // All 16 bits are already in r_shift; SCLK stays high.
                            r_state      <= c_ST_HOLD;
                            mic_cs_n     <= 1'b1;
                            sample       <= r_shift[11:0];
                            sample_valid <= 1'b1;
                            frame_error  <= |r_shift[15:12];
                        end else begin
                            mic_sclk <= 1'b0;
                            r_bit    <= r_bit + 1'b1;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                c_ST_HOLD: begin
                    if (w_div_last) begin
                        r_state <= c_ST_IDLE;
                        r_div   <= '0;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mic_sample_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_mic_sample_receiver
// Description : Scoreboard bench for mic_sample_receiver with an ADC model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mic_sample_receiver;

    typedef struct { logic [11:0] s; logic fe; int cyc; } exp_t;
    typedef struct { bit is_valid; int cyc; } ev_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        mic_sdata = 1'b0;
    logic        mic_cs_n, mic_sclk, sample_valid, frame_error, overrun;
    logic [11:0] sample;

    logic        enable2 = 1'b0;
    logic        sdata2 = 1'b0;
    logic        cs2_n, sclk2, valid2, ferr2, ov2;
    logic [11:0] sample2;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   vcount = 0;
    int   ov_main = 0;
    bit   done2 = 1'b0;
    logic [15:0] word = 16'h0000;
    exp_t sb[$];
    ev_t  sb2[$];
    exp_t e_main;
    ev_t  e2;

    mic_sample_receiver #(.CLK_DIV(25), .SAMPLE_DIV(5000)) u_dut (
        .clock(clock), .reset(reset), .enable(enable), .mic_sdata(mic_sdata),
        .mic_cs_n(mic_cs_n), .mic_sclk(mic_sclk), .sample(sample),
        .sample_valid(sample_valid), .frame_error(frame_error), .overrun(overrun)
    );

    mic_sample_receiver #(.CLK_DIV(25), .SAMPLE_DIV(800)) u_dut_ov (
        .clock(clock), .reset(reset), .enable(enable2), .mic_sdata(sdata2),
        .mic_cs_n(cs2_n), .mic_sclk(sclk2), .sample(sample2),
        .sample_valid(valid2), .frame_error(ferr2), .overrun(ov2)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ADC model: bit k is presented until the k-th SCLK rising edge has been seen.
    int adc_rises = 0;
    logic adc_prev_sclk = 1'b1;
    always @(negedge clock) begin
        if (mic_cs_n) adc_rises = 0;
        else if (mic_sclk && !adc_prev_sclk) adc_rises++;
        adc_prev_sclk = mic_sclk;
        mic_sdata = (adc_rises < 16) ? word[15 - adc_rises] : 1'b0;
    end

    always @(negedge clock) begin
        if (sample_valid) begin
            vcount++;
            if (sb.size() == 0) check("unexpected_valid", 1, 0);
            else begin
                e_main = sb.pop_front();
                check("sample", int'(sample), int'(e_main.s));
                check("frame_error", int'(frame_error), int'(e_main.fe));
                check("valid_cycle", cyc, e_main.cyc);
            end
        end else if (frame_error) check("stray_frame_error", 1, 0);
        if (overrun) ov_main++;
    end

    always @(negedge clock) begin
        if (valid2 || ov2) begin
            if (sb2.size() == 0) check("unexpected_event2", 1, 0);
            else begin
                e2 = sb2.pop_front();
                check("event2_kind", int'(valid2), int'(e2.is_valid));
                check("event2_cycle", cyc, e2.cyc);
                if (valid2) check("sample2", int'(sample2), 0);
            end
        end
    end

    // Frame timing checker on the default-parameter instance.
    int low_len = 0, rises = 0, last_rise = -1, prev_fall = 0, falls = 0;
    bit bad_per = 0, in_frame = 0;
    logic prev_cs = 1'b1, prev_sclk = 1'b1;
    always @(negedge clock) begin
        if (!enable) prev_fall = 0;
        if (reset) in_frame = 0;
        if (prev_cs && !mic_cs_n) begin
            falls++;
            if (prev_fall != 0) check("cs_fall_interval", cyc - prev_fall, 5000);
            prev_fall = cyc;
            in_frame = 1; low_len = 0; rises = 0; last_rise = -1; bad_per = 0;
        end
        if (!mic_cs_n) begin
            low_len++;
            if (mic_sclk && !prev_sclk) begin
                rises++;
                if (last_rise >= 0 && cyc - last_rise != 50) bad_per = 1;
                last_rise = cyc;
            end
        end
        if (!prev_cs && mic_cs_n && in_frame) begin
            in_frame = 0;
            check("cs_low_cycles", low_len, 825);
            check("sclk_rises", rises, 16);
            check("sclk_period_ok", int'(bad_per), 0);
        end
        prev_cs = mic_cs_n;
        prev_sclk = mic_sclk;
    end

    task automatic wait_valid(int n, int budget);
        int k = 0;
        while (vcount < n && k < budget) begin @(negedge clock); k++; end
        if (vcount < n) check("valid_timeout", vcount, n);
    endtask

    task automatic wait_cs_fall(int budget);
        int k = 0;
        while (mic_cs_n && k < budget) begin @(negedge clock); k++; end
        if (mic_cs_n) check("cs_fall_timeout", 1, 0);
    endtask

    task automatic push(logic [11:0] s, logic fe, int c);
        exp_t e;
        e.s = s; e.fe = fe; e.cyc = c;
        sb.push_back(e);
    endtask

    // SAMPLE_DIV=800 instance: ticks alternate between frame start and overrun.
    initial begin
        int n2;
        ev_t ev;
        repeat (6) @(negedge clock);
        n2 = cyc;
        enable2 = 1'b1;
        for (int j = 0; j < 3; j++) begin
            ev.is_valid = 1'b0; ev.cyc = n2 + 1600 + 1600 * j; sb2.push_back(ev);
            ev.is_valid = 1'b1; ev.cyc = n2 + 1625 + 1600 * j; sb2.push_back(ev);
        end
        ev.is_valid = 1'b1; ev.cyc = n2 + 6425; sb2.push_back(ev);
        repeat (6000) @(negedge clock);
        enable2 = 1'b0;
        repeat (600) @(negedge clock);
        done2 = 1'b1;
    end

    initial begin
        int n;
        int k;
        repeat (5) @(negedge clock);
        check("rst_cs_n", int'(mic_cs_n), 1);
        check("rst_sclk", int'(mic_sclk), 1);
        check("rst_sample", int'(sample), 0);
        check("rst_valid", int'(sample_valid), 0);
        check("rst_frame_error", int'(frame_error), 0);
        check("rst_overrun", int'(overrun), 0);
        reset = 1'b0;
        n = cyc;
        enable = 1'b1;
        word = 16'h0ABC; push(12'hABC, 1'b0, n + 5825);
        wait_valid(1, 7000);
        word = 16'hFABC; push(12'hABC, 1'b1, n + 10825);
        wait_valid(2, 6000);
        word = 16'h0555; push(12'h555, 1'b0, n + 15825);
        wait_valid(3, 6000);
        word = 16'h8000; push(12'h000, 1'b1, n + 20825);
        wait_valid(4, 6000);

        // Enable dropped mid-SHIFT: this frame still completes, no more follow.
        word = 16'h0F0F; push(12'hF0F, 1'b0, n + 25825);
        wait_cs_fall(6000);
        repeat (300) @(negedge clock);
        enable = 1'b0;
        wait_valid(5, 1000);
        repeat (6000) @(negedge clock);

        // Reset mid-SHIFT: frame aborted, no valid, sample cleared.
        word = 16'h0777;
        enable = 1'b1;
        wait_cs_fall(6000);
        repeat (300) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_cs_n", int'(mic_cs_n), 1);
        check("abort_sclk", int'(mic_sclk), 1);
        check("abort_sample", int'(sample), 0);
        check("abort_valid", int'(sample_valid), 0);
        @(negedge clock);
        reset = 1'b0;
        enable = 1'b0;
        repeat (1000) @(negedge clock);

        k = 0;
        while (!done2 && k < 10000) begin @(negedge clock); k++; end
        check("ov_bench_done", int'(done2), 1);
        check("cs_fall_total", falls, 6);
        check("valid_total", vcount, 5);
        check("sb_left", sb.size(), 0);
        check("sb2_left", sb2.size(), 0);
        check("main_overruns", ov_main, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
